// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
// Imported by the arbiter top and its lane-alignment helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ERR   = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering between requester-aligned data and the
// 64-bit memory word: strobes, write shift, read shift, misalignment check.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [2:0]  i_req_off,
  input  logic [1:0]  i_size,
  input  logic [63:0] i_wdata,
  input  logic [2:0]  i_rsp_off,
  input  logic [63:0] i_rdata,
  output logic [7:0]  o_wstrb,
  output logic [63:0] o_wdata,
  output logic [63:0] o_rdata,
  output logic        o_misaligned
);

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      SZ_D:    return 8'hFF;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] off);
    case (sz)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return |off[1:0];
      SZ_D:    return |off;
      default: return |off;
    endcase
  endfunction

  logic [5:0] w_req_sh;
  logic [5:0] w_rsp_sh;

  assign w_req_sh     = {i_req_off, 3'b000};
  assign w_rsp_sh     = {i_rsp_off, 3'b000};
  assign o_wstrb      = size_mask(i_size) << i_req_off;
  assign o_wdata      = i_wdata << w_req_sh;
  assign o_rdata      = i_rdata >> w_rsp_sh;
  assign o_misaligned = is_misaligned(i_size, i_req_off);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the MEM
// stage; one transaction in flight, data priority with fetch starvation guard.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rsp_instr,
  input  logic              dm_req_valid,
  input  logic [ADDR_W-1:0] dm_req_addr,
  input  logic              dm_req_we,
  input  logic [1:0]        dm_req_size,
  input  logic [63:0]       dm_req_wdata,
  output logic              dm_req_ready,
  output logic              dm_rsp_valid,
  output logic [63:0]       dm_rsp_rdata,
  output logic              dm_rsp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wstrb,
  input  logic              mem_rsp_valid,
  input  logic [63:0]       mem_rdata,
  output logic              busy
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  arb_state_e        r_state;
  owner_e            r_owner;
  logic [CW-1:0]     r_starve;
  logic [2:0]        r_off;
  logic              r_mem_req_valid;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [63:0]       r_mem_wdata;
  logic [7:0]        r_mem_wstrb;
  logic              r_if_rsp_valid;
  logic [31:0]       r_if_rsp_instr;
  logic              r_dm_rsp_valid;
  logic [63:0]       r_dm_rsp_rdata;
  logic              r_dm_rsp_err;

  logic              w_idle;
  logic              w_if_force;
  logic              w_grant_if;
  logic              w_grant_dm;
  logic [7:0]        w_wstrb;
  logic [63:0]       w_wdata;
  logic [63:0]       w_rdata;
  logic              w_misaligned;

  mem_lane_align u_align (
    .i_req_off    (dm_req_addr[2:0]),
    .i_size       (dm_req_size),
    .i_wdata      (dm_req_wdata),
    .i_rsp_off    (r_off),
    .i_rdata      (mem_rdata),
    .o_wstrb      (w_wstrb),
    .o_wdata      (w_wdata),
    .o_rdata      (w_rdata),
    .o_misaligned (w_misaligned)
  );

  // Readies are gated by reset so every output reads 0 while it is held.
  assign w_idle     = (r_state == IDLE) && reset;
  assign w_if_force = if_req_valid && (r_starve == LIMIT);
  assign w_grant_if = w_idle && if_req_valid && (w_if_force || !dm_req_valid);
  assign w_grant_dm = w_idle && dm_req_valid && !w_if_force;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_owner         <= OWN_IF;
      r_starve        <= '0;
      r_off           <= '0;
      r_mem_req_valid <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_we        <= 1'b0;
      r_mem_wdata     <= '0;
      r_mem_wstrb     <= '0;
      r_if_rsp_valid  <= 1'b0;
      r_if_rsp_instr  <= '0;
      r_dm_rsp_valid  <= 1'b0;
      r_dm_rsp_rdata  <= '0;
      r_dm_rsp_err    <= 1'b0;
    end else begin
      r_if_rsp_valid <= 1'b0;
      r_dm_rsp_valid <= 1'b0;
      r_dm_rsp_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_if) begin
            r_owner         <= OWN_IF;
            r_off           <= if_req_addr[2:0];
            r_mem_addr      <= {if_req_addr[ADDR_W-1:3], 3'b000};
            r_mem_we        <= 1'b0;
            r_mem_wdata     <= '0;
            r_mem_wstrb     <= '0;
            r_mem_req_valid <= 1'b1;
            r_starve        <= '0;
            r_state         <= ISSUE;
          end else if (w_grant_dm) begin
            r_owner     <= OWN_DM;
            r_off       <= dm_req_addr[2:0];
            r_mem_addr  <= {dm_req_addr[ADDR_W-1:3], 3'b000};
            r_mem_we    <= dm_req_we;
            r_mem_wdata <= w_wdata;
            r_mem_wstrb <= dm_req_we ? w_wstrb : 8'h00;
            if (if_req_valid && (r_starve != LIMIT))
              r_starve <= r_starve + CW'(1);
            if (w_misaligned) begin
              r_state <= ERR;
            end else begin
              r_mem_req_valid <= 1'b1;
              r_state         <= ISSUE;
            end
          end
        end
        // Responses arriving alongside the handshake are ignored: memory latency is >= 1.
        ISSUE: begin
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            r_state <= IDLE;
            if (r_owner == OWN_IF) begin
              r_if_rsp_valid <= 1'b1;
              r_if_rsp_instr <= r_off[2] ? mem_rdata[63:32] : mem_rdata[31:0];
            end else begin
              r_dm_rsp_valid <= 1'b1;
              r_dm_rsp_rdata <= r_mem_we ? 64'd0 : w_rdata;
            end
          end
        end
        ERR: begin
          r_dm_rsp_valid <= 1'b1;
          r_dm_rsp_err   <= 1'b1;
          r_dm_rsp_rdata <= '0;
          r_state        <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign if_req_ready  = w_grant_if;
  assign dm_req_ready  = w_grant_dm;
  assign if_rsp_valid  = r_if_rsp_valid;
  assign if_rsp_instr  = r_if_rsp_instr;
  assign dm_rsp_valid  = r_dm_rsp_valid;
  assign dm_rsp_rdata  = r_dm_rsp_rdata;
  assign dm_rsp_err    = r_dm_rsp_err;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_addr      = r_mem_addr;
  assign mem_we        = r_mem_we;
  assign mem_wdata     = r_mem_wdata;
  assign mem_wstrb     = r_mem_wstrb;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter; inputs change and outputs are
// sampled on the falling clock edge.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req_valid;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_req_ready;
  logic              if_rsp_valid;
  logic [31:0]       if_rsp_instr;
  logic              dm_req_valid;
  logic [ADDR_W-1:0] dm_req_addr;
  logic              dm_req_we;
  logic [1:0]        dm_req_size;
  logic [63:0]       dm_req_wdata;
  logic              dm_req_ready;
  logic              dm_rsp_valid;
  logic [63:0]       dm_rsp_rdata;
  logic              dm_rsp_err;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [63:0]       mem_wdata;
  logic [7:0]        mem_wstrb;
  logic              mem_rsp_valid;
  logic [63:0]       mem_rdata;
  logic              busy;

  int vectors    = 0;
  int miscompares = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .if_req_valid  (if_req_valid),
    .if_req_addr   (if_req_addr),
    .if_req_ready  (if_req_ready),
    .if_rsp_valid  (if_rsp_valid),
    .if_rsp_instr  (if_rsp_instr),
    .dm_req_valid  (dm_req_valid),
    .dm_req_addr   (dm_req_addr),
    .dm_req_we     (dm_req_we),
    .dm_req_size   (dm_req_size),
    .dm_req_wdata  (dm_req_wdata),
    .dm_req_ready  (dm_req_ready),
    .dm_rsp_valid  (dm_rsp_valid),
    .dm_rsp_rdata  (dm_rsp_rdata),
    .dm_rsp_err    (dm_rsp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    reset = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 64'h40;
    dm_req_valid = 1'b1; dm_req_addr = 64'h80;
    repeat (3) @(negedge clk);
    #1;
    vectors++; if (if_req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_if_ready got %b want 0", if_req_ready); end
    vectors++; if (dm_req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_dm_ready got %b want 0", dm_req_ready); end
    vectors++; if ({mem_req_valid, mem_we, busy, if_rsp_valid, dm_rsp_valid, dm_rsp_err} !== 6'b0) begin
      miscompares++; $display("FAIL rst_ctrl got %b want 000000", {mem_req_valid, mem_we, busy, if_rsp_valid, dm_rsp_valid, dm_rsp_err}); end
    vectors++; if ({mem_addr, mem_wdata, mem_wstrb} !== '0) begin miscompares++; $display("FAIL rst_mem_fields got %h/%h/%h want 0", mem_addr, mem_wdata, mem_wstrb); end
    vectors++; if ({if_rsp_instr, dm_rsp_rdata} !== '0) begin miscompares++; $display("FAIL rst_rsp_data got %h/%h want 0", if_rsp_instr, dm_rsp_rdata); end
    if_req_valid = 1'b0; dm_req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch;
    if_req_valid = 1'b1; if_req_addr = 64'h104;
    #1;
    vectors++; if (if_req_ready !== 1'b1) begin miscompares++; $display("FAIL fetch_ready got %b want 1", if_req_ready); end
    @(negedge clk);
    if_req_valid = 1'b0;
    vectors++; if (mem_req_valid !== 1'b1) begin miscompares++; $display("FAIL fetch_req_valid got %b want 1", mem_req_valid); end
    vectors++; if (mem_addr !== 64'h100) begin miscompares++; $display("FAIL fetch_addr got %h want %h", mem_addr, 64'h100); end
    vectors++; if ({mem_we, mem_wstrb} !== 9'd0) begin miscompares++; $display("FAIL fetch_we_strb got %b/%h want 0/00", mem_we, mem_wstrb); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL fetch_busy got %b want 1", busy); end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL fetch_req_drop got %b want 0", mem_req_valid); end
    @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rdata = 64'hDEADBEEF_00500093;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    vectors++; if (if_rsp_valid !== 1'b1) begin miscompares++; $display("FAIL fetch_rsp_valid got %b want 1", if_rsp_valid); end
    vectors++; if (if_rsp_instr !== 32'hDEADBEEF) begin miscompares++; $display("FAIL fetch_instr got %h want deadbeef", if_rsp_instr); end
    vectors++; if (dm_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL fetch_dm_quiet got %b want 0", dm_rsp_valid); end
    @(negedge clk);
    vectors++; if ({if_rsp_valid, busy} !== 2'b00) begin miscompares++; $display("FAIL fetch_pulse_end got %b want 00", {if_rsp_valid, busy}); end
  endtask

  task automatic test_store_half;
    dm_req_valid = 1'b1; dm_req_addr = 64'h1006; dm_req_size = 2'd1;
    dm_req_we = 1'b1; dm_req_wdata = 64'h1234;
    #1;
    vectors++; if ({dm_req_ready, if_req_ready} !== 2'b10) begin miscompares++; $display("FAIL st_ready got %b want 10", {dm_req_ready, if_req_ready}); end
    @(negedge clk);
    dm_req_valid = 1'b0;
    vectors++; if (mem_addr !== 64'h1000) begin miscompares++; $display("FAIL st_addr got %h want 1000", mem_addr); end
    vectors++; if (mem_wstrb !== 8'hC0) begin miscompares++; $display("FAIL st_wstrb got %h want c0", mem_wstrb); end
    vectors++; if (mem_wdata !== 64'h1234_0000_0000_0000) begin miscompares++; $display("FAIL st_wdata got %h want 1234000000000000", mem_wdata); end
    vectors++; if ({mem_req_valid, mem_we} !== 2'b11) begin miscompares++; $display("FAIL st_valid_we got %b want 11", {mem_req_valid, mem_we}); end
    @(negedge clk);
    vectors++; if ({mem_req_valid, mem_wstrb, mem_addr} !== {1'b1, 8'hC0, 64'h1000}) begin
      miscompares++; $display("FAIL st_hold got %b/%h/%h want 1/c0/1000", mem_req_valid, mem_wstrb, mem_addr); end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    vectors++; if ({dm_rsp_valid, dm_rsp_err} !== 2'b10) begin miscompares++; $display("FAIL st_rsp got %b want 10", {dm_rsp_valid, dm_rsp_err}); end
    vectors++; if (dm_rsp_rdata !== 64'd0) begin miscompares++; $display("FAIL st_rdata got %h want 0", dm_rsp_rdata); end
    @(negedge clk);
    vectors++; if (dm_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL st_pulse_end got %b want 0", dm_rsp_valid); end
  endtask

  task automatic test_load_word;
    dm_req_valid = 1'b1; dm_req_addr = 64'h2004; dm_req_size = 2'd2;
    dm_req_we = 1'b0; dm_req_wdata = 64'h0;
    @(negedge clk);
    dm_req_valid = 1'b0;
    vectors++; if ({mem_addr, mem_we, mem_wstrb} !== {64'h2000, 1'b0, 8'h00}) begin
      miscompares++; $display("FAIL ld_fields got %h/%b/%h want 2000/0/00", mem_addr, mem_we, mem_wstrb); end
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 64'h5555_5555_5555_5555;
    @(negedge clk);
    mem_req_ready = 1'b0;
    vectors++; if ({dm_rsp_valid, busy} !== 2'b01) begin miscompares++; $display("FAIL ld_early_rsp got %b want 01", {dm_rsp_valid, busy}); end
    mem_rsp_valid = 1'b1; mem_rdata = 64'hFFFFFFEC_00000000;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    vectors++; if ({dm_rsp_valid, dm_rsp_err} !== 2'b10) begin miscompares++; $display("FAIL ld_rsp got %b want 10", {dm_rsp_valid, dm_rsp_err}); end
    vectors++; if (dm_rsp_rdata !== 64'h00000000_FFFFFFEC) begin miscompares++; $display("FAIL ld_rdata got %h want 00000000ffffffec", dm_rsp_rdata); end
    @(negedge clk);
  endtask

  task automatic test_misaligned;
    dm_req_valid = 1'b1; dm_req_addr = 64'h3003; dm_req_size = 2'd2; dm_req_we = 1'b0;
    #1;
    vectors++; if (dm_req_ready !== 1'b1) begin miscompares++; $display("FAIL mis_ready got %b want 1", dm_req_ready); end
    @(negedge clk);
    dm_req_valid = 1'b0;
    vectors++; if ({mem_req_valid, dm_rsp_valid, busy} !== 3'b001) begin
      miscompares++; $display("FAIL mis_err_state got %b want 001", {mem_req_valid, dm_rsp_valid, busy}); end
    @(negedge clk);
    vectors++; if ({dm_rsp_valid, dm_rsp_err, mem_req_valid, busy} !== 4'b1100) begin
      miscompares++; $display("FAIL mis_rsp got %b want 1100", {dm_rsp_valid, dm_rsp_err, mem_req_valid, busy}); end
    vectors++; if (dm_rsp_rdata !== 64'd0) begin miscompares++; $display("FAIL mis_rdata got %h want 0", dm_rsp_rdata); end
    @(negedge clk);
    vectors++; if ({dm_rsp_valid, dm_rsp_err, mem_req_valid} !== 3'b000) begin
      miscompares++; $display("FAIL mis_end got %b want 000", {dm_rsp_valid, dm_rsp_err, mem_req_valid}); end
  endtask

  task automatic test_contention;
    logic exp_if;
    if_req_valid = 1'b1; if_req_addr = 64'h200;
    dm_req_valid = 1'b1; dm_req_addr = 64'h400; dm_req_size = 2'd3; dm_req_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_if = (i == 4) || (i == 9);
      #1;
      vectors++; if ({if_req_ready, dm_req_ready} !== {exp_if, ~exp_if}) begin
        miscompares++; $display("FAIL cont_grant[%0d] got if/dm %b want %b", i, {if_req_ready, dm_req_ready}, {exp_if, ~exp_if}); end
      @(negedge clk);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1; mem_rdata = 64'h11111111_22222222;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      if (exp_if) begin
        vectors++; if ({if_rsp_valid, dm_rsp_valid, if_rsp_instr} !== {2'b10, 32'h22222222}) begin
          miscompares++; $display("FAIL cont_if_rsp[%0d] got %b/%h want 10/22222222", i, {if_rsp_valid, dm_rsp_valid}, if_rsp_instr); end
      end else begin
        vectors++; if ({if_rsp_valid, dm_rsp_valid, dm_rsp_rdata} !== {2'b01, 64'h11111111_22222222}) begin
          miscompares++; $display("FAIL cont_dm_rsp[%0d] got %b/%h want 01/1111111122222222", i, {if_rsp_valid, dm_rsp_valid}, dm_rsp_rdata); end
      end
    end
    if_req_valid = 1'b0; dm_req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait;
    if_req_valid = 1'b1; if_req_addr = 64'h308;
    @(negedge clk);
    if_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    vectors++; if ({busy, mem_req_valid} !== 2'b10) begin miscompares++; $display("FAIL mid_wait got %b want 10", {busy, mem_req_valid}); end
    reset = 1'b0;
    #1;
    vectors++; if ({busy, mem_req_valid, mem_addr} !== '0) begin
      miscompares++; $display("FAIL mid_rst_clear got %b/%b/%h want 0/0/0", busy, mem_req_valid, mem_addr); end
    @(negedge clk);
    reset = 1'b1;
    mem_rsp_valid = 1'b1; mem_rdata = 64'hCAFEF00D_12345678;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    vectors++; if ({if_rsp_valid, dm_rsp_valid, busy, mem_req_valid} !== 4'b0000) begin
      miscompares++; $display("FAIL late_rsp got %b want 0000", {if_rsp_valid, dm_rsp_valid, busy, mem_req_valid}); end
    vectors++; if ({if_rsp_instr, dm_rsp_rdata, mem_addr} !== '0) begin
      miscompares++; $display("FAIL late_rsp_data got %h/%h/%h want 0", if_rsp_instr, dm_rsp_rdata, mem_addr); end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    if_req_valid = 1'b0; if_req_addr = '0;
    dm_req_valid = 1'b0; dm_req_addr = '0; dm_req_we = 1'b0;
    dm_req_size = 2'd0; dm_req_wdata = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    test_reset();
    test_fetch();
    test_store_half();
    test_load_word();
    test_misaligned();
    test_contention();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
